// File: rtl/handshake_fifo_buffer.sv
// Elastic handshake FIFO: circular register buffer, 1-cycle latency, full throughput.
// ins_ready and outs_valid come from registered occupancy only.
module handshake_fifo_buffer #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_SLOTS  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] ins,
  input  logic                  ins_valid,
  output logic                  ins_ready,
  output logic [DATA_WIDTH-1:0] outs,
  output logic                  outs_valid,
  input  logic                  outs_ready
);

  localparam int unsigned PtrW = $clog2(NUM_SLOTS);
  localparam int unsigned CntW = $clog2(NUM_SLOTS + 1);
  localparam logic [PtrW-1:0] LastPtr = PtrW'(NUM_SLOTS - 1);
  localparam logic [CntW-1:0] FullCnt = CntW'(NUM_SLOTS);

  logic [DATA_WIDTH-1:0] mem_q [NUM_SLOTS];
  logic [PtrW-1:0]       head_q, head_d;
  logic [PtrW-1:0]       tail_q, tail_d;
  logic [CntW-1:0]       count_q, count_d;
  logic                  push, pop;

  assign outs_valid = (count_q != '0);
  assign ins_ready  = (count_q != FullCnt);
  assign outs       = mem_q[head_q];

  assign push = ins_valid & ins_ready;
  assign pop  = outs_valid & outs_ready;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (push) tail_d = (tail_q == LastPtr) ? '0 : tail_q + PtrW'(1);
    if (pop)  head_d = (head_q == LastPtr) ? '0 : head_q + PtrW'(1);
    if (push && !pop) begin
      count_d = count_q + CntW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      if (push) mem_q[tail_q] <= ins;
    end
  end

endmodule

// File: tb/tb_handshake_fifo_buffer.sv
// Bench for handshake_fifo_buffer: a 4-slot and a 3-slot instance share stimulus,
// each tracked by its own scoreboard queue.
module tb_handshake_fifo_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ins;
  logic        ins_valid;
  logic        outs_ready;
  logic        ins_ready4, outs_valid4, ins_ready3, outs_valid3;
  logic [31:0] outs4, outs3;

  always #5 clk = ~clk;

  handshake_fifo_buffer #(.DATA_WIDTH(32), .NUM_SLOTS(4)) u_dut4 (
    .clk        (clk),
    .rst        (rst),
    .ins        (ins),
    .ins_valid  (ins_valid),
    .ins_ready  (ins_ready4),
    .outs       (outs4),
    .outs_valid (outs_valid4),
    .outs_ready (outs_ready)
  );

  handshake_fifo_buffer #(.DATA_WIDTH(32), .NUM_SLOTS(3)) u_dut3 (
    .clk        (clk),
    .rst        (rst),
    .ins        (ins),
    .ins_valid  (ins_valid),
    .ins_ready  (ins_ready3),
    .outs       (outs3),
    .outs_valid (outs_valid3),
    .outs_ready (outs_ready)
  );

  logic [31:0] q4[$];
  logic [31:0] q3[$];
  int          n_pass = 0, n_checks = 0, n_fail = 0;
  int          pops4 = 0, pops3 = 0;
  bit          acc4 = 0;
  bit          hold4 = 0, hold3 = 0;
  logic [31:0] held4, held3;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called in the low phase with inputs settled; scores this cycle's transfers, then
  // advances to the next falling edge.
  task automatic tick();
    acc4 = 0;
    if (!rst) begin
      check("valid4", {31'b0, outs_valid4}, {31'b0, q4.size() != 0});
      check("ready4", {31'b0, ins_ready4}, {31'b0, q4.size() != 4});
      check("valid3", {31'b0, outs_valid3}, {31'b0, q3.size() != 0});
      check("ready3", {31'b0, ins_ready3}, {31'b0, q3.size() != 3});
      if (hold4) check("stable4", outs4, held4);
      if (hold3) check("stable3", outs3, held3);
      if (outs_valid4 && outs_ready && q4.size() != 0) begin
        check("order4", outs4, q4.pop_front());
        pops4++;
      end
      if (outs_valid3 && outs_ready && q3.size() != 0) begin
        check("order3", outs3, q3.pop_front());
        pops3++;
      end
      if (ins_valid && ins_ready4) begin
        q4.push_back(ins);
        acc4 = 1;
      end
      if (ins_valid && ins_ready3) q3.push_back(ins);
      hold4 = outs_valid4 && !outs_ready;
      held4 = outs4;
      hold3 = outs_valid3 && !outs_ready;
      held3 = outs3;
    end
    @(posedge clk);
    @(negedge clk);
    if (rst) begin
      q4.delete();
      q3.delete();
      hold4 = 0;
      hold3 = 0;
    end
  endtask

  initial begin
    int p0;
    int cyc;
    rst = 1'b1;
    ins = '0;
    ins_valid = 1'b0;
    outs_ready = 1'b0;
    @(negedge clk);
    tick();
    rst = 1'b0;

    // Reset, then idle
    for (int i = 0; i < 3; i++) begin
      check("t1_outs4", outs4, 32'h0);
      check("t1_outs3", outs3, 32'h0);
      tick();
    end

    // Single token, one cycle latency
    outs_ready = 1'b1;
    ins = 32'h0F;
    ins_valid = 1'b1;
    tick();
    ins_valid = 1'b0;
    check("t2_valid", {31'b0, outs_valid4}, 32'h1);
    check("t2_data", outs4, 32'h0F);
    tick();
    check("t2_empty", {31'b0, outs_valid4}, 32'h0);

    // Fill with consumer stalled, then offer a fifth token
    outs_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      ins = i;
      ins_valid = 1'b1;
      tick();
    end
    check("t3_full", {31'b0, ins_ready4}, 32'h0);
    ins = 32'd5;
    tick();
    tick();
    check("t3_held_out", outs4, 32'd1);
    outs_ready = 1'b1;
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while (!acc4 && cyc < 10);
    check("t3_accept5", {31'b0, acc4}, 32'h1);
    ins_valid = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    check("t3_drained", {31'b0, outs_valid4}, 32'h0);

    // Streaming 0..9 at full rate
    p0 = pops4;
    for (int i = 0; i < 10; i++) begin
      ins = i;
      ins_valid = 1'b1;
      tick();
    end
    ins_valid = 1'b0;
    tick();
    check("t4_rate", pops4 - p0, 32'd10);
    check("t4_empty", {31'b0, outs_valid4}, 32'h0);

    // Random traffic: 10k tokens through the 3-slot instance
    p0 = pops3;
    cyc = 0;
    while (pops3 - p0 < 10000 && cyc < 60000) begin
      ins = $urandom;
      ins_valid = $urandom_range(0, 1) == 1;
      outs_ready = $urandom_range(0, 1) == 1;
      tick();
      cyc++;
    end
    check("t5_done", {31'b0, pops3 - p0 >= 10000}, 32'h1);
    ins_valid = 1'b0;
    outs_ready = 1'b1;
    for (int i = 0; i < 6; i++) tick();

    // Reset a full buffer: stored tokens vanish
    outs_ready = 1'b0;
    for (int i = 7; i <= 10; i++) begin
      ins = i;
      ins_valid = 1'b1;
      tick();
    end
    check("t6_full", {31'b0, ins_ready4}, 32'h0);
    ins_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t6_valid", {31'b0, outs_valid4}, 32'h0);
    check("t6_ready", {31'b0, ins_ready4}, 32'h1);
    check("t6_outs", outs4, 32'h0);
    p0 = pops4;
    outs_ready = 1'b1;
    ins = 32'h0F;
    ins_valid = 1'b1;
    tick();
    ins_valid = 1'b0;
    check("t6_first", outs4, 32'h0F);
    tick();
    tick();
    check("t6_single", pops4 - p0, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
